// File: rtl/demux_1x_n_reg.sv
// rtl/demux_1x_n_reg.sv - registered 1-to-N valid/ready stream demux, one-entry holding register
// Define DEMUX_ERR_EN to add the sticky err flag and saturating drop_cnt for out-of-range selects.
module demux_1x_n_reg #(
  parameter int W     = 8,
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready
`ifdef DEMUX_ERR_EN
  ,
  output logic             err,
  output logic [7:0]       drop_cnt
`endif
);

  logic             full_q, full_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [W-1:0]     data_q, data_d;
  logic             live_q;
  logic             sel_ready;
  logic             out_fire;
  logic             in_fire;
  logic             in_range;

  // live_q holds in_ready low for the first cycle after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live_q <= 1'b0;
    else     live_q <= 1'b1;
  end

  always_comb begin
    sel_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (dest_q == SEL_W'(k)) sel_ready = out_ready[k];
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_valid
    assign out_valid[g] = full_q & (dest_q == SEL_W'(g));
  end

  assign out_data = data_q;
  assign out_fire = full_q & sel_ready;
  assign in_ready = live_q & (~full_q | out_fire);
  assign in_fire  = in_valid & in_ready;
  assign in_range = (32'(in_sel) < N);

  // An out-of-range beat is consumed without loading, so it still empties a draining entry
  always_comb begin
    full_d = full_q;
    dest_d = dest_q;
    data_d = data_q;
    if (in_fire && in_range) begin
      full_d = 1'b1;
      dest_d = in_sel;
      data_d = in_data;
    end else if (out_fire) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      dest_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      dest_q <= dest_d;
      data_q <= data_d;
    end
  end

`ifdef DEMUX_ERR_EN
  logic       err_q, err_d;
  logic [7:0] drop_q, drop_d;
  logic       drop;

  assign drop = in_fire & ~in_range;

  always_comb begin
    err_d  = err_q | drop;
    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      drop_q <= 8'h00;
    end else begin
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  assign err      = err_q;
  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux_1x_n_reg.sv
// tb/tb_demux_1x_n_reg.sv - directed and random checks of demux_1x_n_reg with W=8, N=3, SEL_W=2
// Define DEMUX_ERR_EN to also check err/drop_cnt.
module tb_demux_1x_n_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic [1:0] in_sel = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] out_valid;
  logic [2:0] out_ready = 3'b000;
`ifdef DEMUX_ERR_EN
  logic       err;
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_1x_n_reg #(.W(8), .N(3), .SEL_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_ERR_EN
    ,
    .err       (err),
    .drop_cnt  (drop_cnt)
`endif
  );

  // Inputs change at edge+1, outputs are sampled at edge+2.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'h11; in_sel = 2'd0; out_ready = 3'b111;
    cyc(); cyc();
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL reset_out_valid got=%b exp=000", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL release_in_ready_early got=%b exp=0", in_ready); end
    cyc();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL release_ignored_valid got=%b exp=000", out_valid); end
    in_valid = 1'b0;
    cyc();
    // mid-transfer reset while holding a beat
    in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd1; out_ready = 3'b000;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b010) begin failures++; $display("FAIL pre_reset_held got=%b exp=010", out_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL async_reset_valid got=%b exp=000", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL async_reset_data got=%h exp=00", out_data); end
`ifdef DEMUX_ERR_EN
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL async_reset_err got=%b exp=0", err); end
`endif
    cyc();
    rst = 1'b0;
    cyc();
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rerelease_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single();
    cyc();
    in_valid = 1'b1; in_data = 8'hA5; in_sel = 2'd2; out_ready = 3'b111;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL single_no_early got=%b exp=000", out_valid); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b100) begin failures++; $display("FAIL single_valid got=%b exp=100", out_valid); end
    checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", out_data); end
    cyc();
    #1;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL single_one_cycle got=%b exp=000", out_valid); end
  endtask

  task automatic test_streaming();
    logic [2:0] exp_v;
    cyc();
    out_ready = 3'b111;
    for (int i = 0; i <= 16; i++) begin
      in_valid = (i < 16);
      in_data  = 8'h10 + 8'(i);
      in_sel   = 2'(i % 3);
      #1;
      if (i < 16) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready beat=%0d got=%b exp=1", i, in_ready); end
      end
      if (i >= 1) begin
        exp_v = 3'b001 << ((i - 1) % 3);
        checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL stream_valid beat=%0d got=%b exp=%b", i - 1, out_valid, exp_v); end
        checks++; if (out_data !== 8'h10 + 8'(i - 1)) begin failures++; $display("FAIL stream_data beat=%0d got=%h exp=%h", i - 1, out_data, 8'h10 + 8'(i - 1)); end
      end
      cyc();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL stream_drained got=%b exp=000", out_valid); end
  endtask

  task automatic test_back_pressure();
    cyc();
    out_ready = 3'b101;
    in_valid = 1'b1; in_data = 8'h3C; in_sel = 2'd1;
    cyc();
    in_data = 8'h5A; in_sel = 2'd0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_valid !== 3'b010) begin failures++; $display("FAIL bp_valid cycle=%0d got=%b exp=010", c, out_valid); end
      checks++; if (out_data !== 8'h3C) begin failures++; $display("FAIL bp_data cycle=%0d got=%h exp=3c", c, out_data); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
      cyc();
    end
    out_ready = 3'b111;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 3'b010) begin failures++; $display("FAIL bp_release_valid got=%b exp=010", out_valid); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b001) begin failures++; $display("FAIL bp_next_valid got=%b exp=001", out_valid); end
    checks++; if (out_data !== 8'h5A) begin failures++; $display("FAIL bp_next_data got=%h exp=5a", out_data); end
    cyc();
    #1;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL bp_empty got=%b exp=000", out_valid); end
  endtask

  task automatic test_out_of_range();
    cyc();
    out_ready = 3'b111;
    in_valid = 1'b1; in_data = 8'h77; in_sel = 2'd3;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL oor_in_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL oor_no_valid got=%b exp=000", out_valid); end
`ifdef DEMUX_ERR_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", err); end
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL oor_drop1 got=%0d exp=1", drop_cnt); end
`endif
    // held beat draining while an out-of-range beat arrives leaves the entry empty
    cyc();
    in_valid = 1'b1; in_data = 8'h21; in_sel = 2'd0;
    cyc();
    in_data = 8'h77; in_sel = 2'd3;
    #1;
    checks++; if (out_valid !== 3'b001) begin failures++; $display("FAIL oor_drain_held got=%b exp=001", out_valid); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL oor_drain_empty got=%b exp=000", out_valid); end
    cyc();
    in_valid = 1'b1; in_sel = 2'd3;
    for (int i = 0; i < 300; i++) begin
      in_data = 8'(i);
      #1;
      checks++; if (out_valid !== 3'b000) begin failures++; $display("FAIL oor_burst_valid beat=%0d got=%b exp=000", i, out_valid); end
      cyc();
    end
    in_valid = 1'b0;
    #1;
`ifdef DEMUX_ERR_EN
    checks++; if (drop_cnt !== 8'hFF) begin failures++; $display("FAIL oor_saturate got=%h exp=ff", drop_cnt); end
    #1 rst = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_reset_err got=%b exp=0", err); end
    checks++; if (drop_cnt !== 8'h00) begin failures++; $display("FAIL oor_reset_cnt got=%h exp=00", drop_cnt); end
    cyc();
    rst = 1'b0;
    cyc();
`endif
  endtask

  task automatic test_random();
    logic [9:0] exp_q[$];
    logic [9:0] head;
    logic       fire_o;
    logic [1:0] fire_ch;
    logic       exp_rdy;
    cyc();
    for (int c = 0; c < 10000 + 8; c++) begin
      if (c < 10000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_sel    = 2'($urandom_range(0, 3));
        in_data   = 8'($urandom);
        out_ready = 3'($urandom);
      end else begin
        in_valid  = 1'b0;
        out_ready = 3'b111;
      end
      #1;
      fire_o = 1'b0; fire_ch = 2'd0;
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) begin fire_o = 1'b1; fire_ch = 2'(k); end
      end
      checks++; if ($countones(out_valid) > 1) begin failures++; $display("FAIL rnd_onehot cycle=%0d got=%b exp=onehot", c, out_valid); end
      checks++; if ((out_valid != 3'b000) !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_occupancy cycle=%0d got=%b exp_held=%0d", c, out_valid, exp_q.size()); end
      exp_rdy = (exp_q.size() == 0) || fire_o;
      checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready cycle=%0d got=%b exp=%b", c, in_ready, exp_rdy); end
      if (fire_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_dup cycle=%0d got=ch%0d/%h exp=none", c, fire_ch, out_data);
        end else begin
          head = exp_q.pop_front();
          if ({fire_ch, out_data} !== head) begin
            failures++; $display("FAIL rnd_beat cycle=%0d got=ch%0d/%h exp=ch%0d/%h", c, fire_ch, out_data, head[9:8], head[7:0]);
          end
        end
      end
      if (in_valid && in_ready && in_sel != 2'd3) exp_q.push_back({in_sel, in_data});
      cyc();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_loss got=%0d_pending exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_back_pressure();
    test_out_of_range();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
